clock_divider_prog: RTL
=======================

# clock_divider_prog

Parametrised, runtime-programmable clock divider with NUM_CH independent channels, all clocked from the single fabric clock. Each channel generates a divided square wave, plus an optional one-cycle tick on its rising edge, from a per-channel half-period count. Divisor changes use a handshake and take effect only at a toggle boundary, so outputs never glitch. A global sync restarts all channels phase-aligned. The block replaces fixed-ratio dividers feeding slow peripherals and the CNN accelerator's slow-clock-enable domains.

## Interface
Parameters:
- NUM_CH, 2, number of divider channels (1..8)
- CNT_W, 16, width of half-period count and channel counters
- DEF_HALF, 2, reset value of every channel's active half-period count

Ports:
- clk  in  1  fabric clock
- rst_n  in  1  reset; one clock, synchronous, active-low
- en  in  1  global run; low freezes all counters and outputs
- sync  in  1  one-cycle pulse; restart all channels phase-aligned
- cfg_valid  in  1  config request
- cfg_ready  out  1  config accept (combinational)
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel
- cfg_half  in  CNT_W  new half-period count H
- clk_out  out  NUM_CH  divided square waves, registered
- tick  out  NUM_CH  one-cycle pulse per rising edge of clk_out, registered

## Operation
- Per channel state: cnt[CNT_W], act_half[CNT_W], pend_half[CNT_W], pend flag, clk_out bit.
- Half-period = H+1 clk cycles; full period = 2(H+1). H=0 gives divide-by-2. H=2 gives divide-by-6.
- Count step, when en=1 and sync=0:
  - if cnt==act_half: cnt<=0, clk_out toggles; if pend, act_half<=pend_half and pend<=0 (boundary event).
  - else cnt<=cnt+1.
- tick[i]<=1 in exactly the cycles where clk_out[i] is updated 0->1; otherwise 0.
- Config handshake:
  - cfg_ready = ~pend[cfg_ch]; cfg_ch >= NUM_CH gives cfg_ready=1 and the write is dropped.
  - Accept on cfg_valid&cfg_ready: pend_half<=cfg_half, pend<=1.
  - At most one outstanding change per channel; the new value applies at the channel's next boundary event.
- sync=1 (priority over counting, regardless of en): every cnt<=0, clk_out<=0, tick<=0. Any pending value is applied immediately and pend is cleared.
- Same-cycle sync and cfg accept: the accept writes pend_half and sets pend, and that value waits for the next boundary. Any older pending value was already applied by sync.
- en=0: cnt, clk_out and act_half hold; tick=0. Config accepts still occur, but pending values wait for en and a boundary.
- Counter arithmetic: unsigned CNT_W. cnt never exceeds act_half, so no wrap path exists.

## Timing
- Reset (rst_n=0 at posedge): cnt=0, clk_out=0, tick=0, act_half=DEF_HALF, pend=0, pend_half=0. cfg_ready=1 from the first cycle after reset.
- Reset mid-operation discards pending config and restarts phase at 0.
- After reset or sync, the first clk_out rise (and tick) occurs H+1 cycles after the cycle the counter starts at 0. The first high phase lasts H+1 cycles.
- Config latency: the new H governs the half-period that starts right after the next boundary event. The half-period in progress completes with the old H.
- cfg_ready drops in the cycle after acceptance and rises in the cycle after the applying boundary.

## Configuration
- CLKDIV_TICK_EN defined: tick logic compiled in as above.
- Not defined: tick is tied to 0 and its registers are removed. clk_out behaviour is identical.

## Test plan
- Reset, NUM_CH=2, DEF_HALF=2, en=1 -> both clk_out period 6 cycles, 3 high/3 low; tick high once per 6 cycles, coincident with each rise.
- cfg ch0 H=0 mid-high-phase -> ch0 finishes current 3-cycle phase, then toggles every cycle (period 2). cfg_ready low from accept until the cycle after that boundary. ch1 is unaffected.
- Second cfg to ch0 while pending -> cfg_ready=0, no accept. A cfg to ch1 in the same cycle is accepted.
- Set ch1 H=4, then pulse sync -> both clk_out=0 and cnt=0 next cycle, and ch1 applies H=4 immediately. Rises follow at +3 (ch0) and +5 (ch1) cycles, then periods 6 and 10.
- en low for 7 cycles at ch0 cnt=1 -> outputs frozen, tick=0. Resuming en continues from cnt=1 with no extra toggle.
- rst_n low for 1 cycle mid-run with a pending cfg -> all outputs 0, act_half=2, pending discarded, period 6 resumes.

Source files
------------

// File: rtl/clock_divider_prog.sv
// Multi-channel runtime-programmable clock divider; half-period changes load only at toggle edges.
// Define CLKDIV_TICK_EN to build the per-channel rising-edge tick outputs.
module clock_divider_prog #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned DEF_HALF = 2,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [CNT_W-1:0]  cnt_q       [NUM_CH];
  logic [CNT_W-1:0]  cnt_d       [NUM_CH];
  logic [CNT_W-1:0]  act_q       [NUM_CH];
  logic [CNT_W-1:0]  act_d       [NUM_CH];
  logic [CNT_W-1:0]  pend_half_q [NUM_CH];
  logic [CNT_W-1:0]  pend_half_d [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] clk_q, clk_d;
  logic [NUM_CH-1:0] accept;

  // Out-of-range channel numbers match no channel, so they read ready and are dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = ~pend_q[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      accept[i] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(i));
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    act_d       = act_q;
    pend_half_d = pend_half_q;
    pend_d      = pend_q;
    clk_d       = clk_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sync) begin
        cnt_d[i] = '0;
        clk_d[i] = 1'b0;
        if (pend_q[i]) act_d[i] = pend_half_q[i];
        pend_d[i] = 1'b0;
      end else if (en) begin
        if (cnt_q[i] == act_q[i]) begin
          cnt_d[i] = '0;
          clk_d[i] = ~clk_q[i];
          if (pend_q[i]) begin
            act_d[i]  = pend_half_q[i];
            pend_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
      // Accept only happens with pend low, so it never collides with a boundary load.
      if (accept[i]) begin
        pend_half_d[i] = cfg_half;
        pend_d[i]      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]       <= '0;
        act_q[i]       <= CNT_W'(DEF_HALF);
        pend_half_q[i] <= '0;
      end
      pend_q <= '0;
      clk_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      act_q       <= act_d;
      pend_half_q <= pend_half_d;
      pend_q      <= pend_d;
      clk_q       <= clk_d;
    end
  end

  assign clk_out = clk_q;

`ifdef CLKDIV_TICK_EN
  logic [NUM_CH-1:0] tick_q, tick_d;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      tick_d[i] = en & ~sync & (cnt_q[i] == act_q[i]) & ~clk_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) tick_q <= '0;
    else        tick_q <= tick_d;
  end

  assign tick = tick_q;
`else
  assign tick = '0;
`endif

endmodule
